ste_dice_ctrl: RTL
==================

STE_DICE_CTRL -- requirements
Module: ste_dice_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 16'd50000: consecutive equal synchronized button samples required to accept a new level.
REQ-002 Parameter TIMEOUT_CYCLES, default 16'd1000: maximum cycles spent in WAIT before error.
REQ-003 The block SHALL use one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  system clock, all logic on rising edge.
REQ-005 reset_i  input  1  synchronous reset, active high.
REQ-006 btn_i  input  1  raw asynchronous push-button.
REQ-007 dice_done_i  input  1  roll-finished pulse from dice module.
REQ-008 dice_dout_i  input  3  dice value from dice module, registered one cycle after dice_done_i.
REQ-009 trig_pls_o  output  1  trigger to dice module.
REQ-010 busy_o  output  1  high in any state other than IDLE.
REQ-011 result_o  output  3  last valid dice value, 1..6.
REQ-012 result_valid_o  output  1  one-cycle pulse when result_o is updated.
REQ-013 err_o  output  1  sticky error flag, cleared on next roll start.
REQ-014 roll_cnt_o  output  8  count of successful rolls, wraps 255->0.

Function
REQ-015 btn_i SHALL pass a 2-flop synchronizer; debounced level btn_db changes only after DEBOUNCE_CYCLES consecutive synchronized samples differing from btn_db.
REQ-016 start SHALL be a one-cycle pulse on btn_db 0->1; start outside IDLE is ignored and not queued.
REQ-017 FSM states: IDLE, TRIG, WAIT, CAPTURE; encoding free.
REQ-018 IDLE->TRIG on start; err_o cleared same edge.
REQ-019 TRIG: trig_pls_o high for exactly 2 cycles, then ->WAIT with trig_pls_o low; trig_pls_o high in no other state.
REQ-020 WAIT: timeout counter starts at 0, increments per cycle; dice_done_i=1 ->CAPTURE; counter reaching TIMEOUT_CYCLES-1 without done ->IDLE with err_o=1.
REQ-021 dice_done_i and timeout in same cycle: done wins.
REQ-022 CAPTURE (one cycle): sample dice_dout_i; if 1..6, result_o<=value, result_valid_o pulses next cycle, roll_cnt_o increments; if 0 or 7, err_o=1, result_o and roll_cnt_o unchanged, no valid pulse; always ->IDLE.
REQ-023 dice_done_i outside WAIT SHALL be ignored.
REQ-024 Latency: btn_db rise at edge N -> trig_pls_o high at edges N+1, N+2; result_valid_o high exactly 2 cycles after the dice_done_i cycle.

Reset
REQ-025 reset_i=1 at a clock edge SHALL force IDLE, trig_pls_o=0, busy_o=0, result_o=0, result_valid_o=0, err_o=0, roll_cnt_o=0, synchronizer/debounce state=0, counters=0.
REQ-026 Reset mid-roll SHALL abort immediately; a dice_done_i arriving after reset release is ignored (IDLE).

Configuration
REQ-027 Macro STE_DICE_CTRL_DEBOUNCE_EN defined: debounce counter per REQ-015 present.
REQ-028 Macro undefined: btn_db equals the synchronizer output directly, DEBOUNCE_CYCLES unused, no debounce counter synthesized; all other behaviour identical.

Verification (DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=20, macro defined)
REQ-029 btn_i high 10 cycles, dice_done_i 30 cycles later, dice_dout_i=3 next cycle -> trig_pls_o 2 cycles, result_o=3, result_valid_o 1 pulse, roll_cnt_o=1, err_o=0.
REQ-030 btn_i glitches high 2 cycles, low 10 -> no trig_pls_o, busy_o stays 0.
REQ-031 Start, no dice_done_i -> err_o=1 after 20 WAIT cycles, IDLE; next start clears err_o.
REQ-032 dice_done_i followed by dice_dout_i=7 -> err_o=1, result_o keeps previous value, roll_cnt_o unchanged.
REQ-033 Second button press during WAIT -> ignored, exactly one trig sequence; 256 successful rolls -> roll_cnt_o=0.
REQ-034 reset_i high 1 cycle during WAIT -> all outputs per REQ-025 next cycle; subsequent dice_done_i -> no result_valid_o.

Source files
------------

// File: rtl/ste_dice_ctrl.sv
// Push-button dice roll controller: synchronizes and debounces the button, triggers the
// dice module, and validates and counts results. Define STE_DICE_CTRL_DEBOUNCE_EN to enable the debounce counter.
module ste_dice_ctrl #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [15:0] TIMEOUT_CYCLES  = 16'd1000
) (
  input  logic       clk,
  input  logic       reset_i,
  input  logic       btn_i,
  input  logic       dice_done_i,
  input  logic [2:0] dice_dout_i,
  output logic       trig_pls_o,
  output logic       busy_o,
  output logic [2:0] result_o,
  output logic       result_valid_o,
  output logic       err_o,
  output logic [7:0] roll_cnt_o
);

  typedef enum logic [1:0] {S_IDLE, S_TRIG, S_WAIT, S_CAPT} state_t;

  state_t      r_state, w_next;
  logic        r_sync1, r_sync2;
  logic        w_btn_db, r_btn_db_d, w_start;
  logic        r_trig_cnt;
  logic [15:0] r_to_cnt;
  logic        w_timeout, w_cap_ok, w_cap_bad;

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= btn_i;
      r_sync2 <= r_sync1;
    end
  end

`ifdef STE_DICE_CTRL_DEBOUNCE_EN
  logic        r_btn_db;
  logic [15:0] r_db_cnt;

  // Any sample agreeing with the current level restarts the run of differing samples.
  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_btn_db <= 1'b0;
      r_db_cnt <= 16'd0;
    end else if (r_sync2 != r_btn_db) begin
      if (r_db_cnt == DEBOUNCE_CYCLES - 16'd1) begin
        r_btn_db <= r_sync2;
        r_db_cnt <= 16'd0;
      end else begin
        r_db_cnt <= r_db_cnt + 16'd1;
      end
    end else begin
      r_db_cnt <= 16'd0;
    end
  end

  assign w_btn_db = r_btn_db;
`else
  assign w_btn_db = r_sync2;
`endif

  always_ff @(posedge clk) begin
    if (reset_i) r_btn_db_d <= 1'b0;
    else         r_btn_db_d <= w_btn_db;
  end

  assign w_start = w_btn_db & ~r_btn_db_d;

  always_ff @(posedge clk) begin
    if (reset_i) r_state <= S_IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    trig_pls_o = 1'b0;
    busy_o     = (r_state != S_IDLE);
    w_timeout  = 1'b0;
    w_cap_ok   = 1'b0;
    w_cap_bad  = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) w_next = S_TRIG;
      S_TRIG: begin
        trig_pls_o = 1'b1;
        if (r_trig_cnt) w_next = S_WAIT;
      end
      S_WAIT: begin
        // done takes priority over a timeout in the same cycle
        if (dice_done_i) begin
          w_next = S_CAPT;
        end else if (r_to_cnt == TIMEOUT_CYCLES - 16'd1) begin
          w_next    = S_IDLE;
          w_timeout = 1'b1;
        end
      end
      S_CAPT: begin
        w_next = S_IDLE;
        if (dice_dout_i >= 3'd1 && dice_dout_i <= 3'd6) w_cap_ok  = 1'b1;
        else                                             w_cap_bad = 1'b1;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      r_trig_cnt <= 1'b0;
      r_to_cnt   <= 16'd0;
    end else begin
      r_trig_cnt <= (r_state == S_TRIG) && !r_trig_cnt;
      r_to_cnt   <= (r_state == S_WAIT) ? r_to_cnt + 16'd1 : 16'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_i) begin
      result_o       <= 3'd0;
      result_valid_o <= 1'b0;
      err_o          <= 1'b0;
      roll_cnt_o     <= 8'd0;
    end else begin
      result_valid_o <= w_cap_ok;
      if (w_cap_ok) begin
        result_o   <= dice_dout_i;
        roll_cnt_o <= roll_cnt_o + 8'd1;
      end
      if (r_state == S_IDLE && w_start) err_o <= 1'b0;
      else if (w_timeout || w_cap_bad)  err_o <= 1'b1;
    end
  end

endmodule
